// File: rtl/mavg_window.sv
// Multi-channel moving-average window with per-channel circular buffer.
// Ports: clk, rst (async high), clr, win_sel, in_valid, data_in -> out_valid, avg_out, evict_out, primed.
module mavg_window #(
  parameter int DATA_WIDTH   = 16,
  parameter int NUM_CH       = 8,
  parameter int MAX_LOG2_WIN = 6
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 clr,
  input  logic [$clog2(MAX_LOG2_WIN+1)-1:0]    win_sel,
  input  logic                                 in_valid,
  input  logic [NUM_CH*DATA_WIDTH-1:0]         data_in,
  output logic                                 out_valid,
  output logic [NUM_CH*DATA_WIDTH-1:0]         avg_out,
  output logic [NUM_CH*DATA_WIDTH-1:0]         evict_out,
  output logic                                 primed
);

  localparam int SUM_WIDTH = DATA_WIDTH + MAX_LOG2_WIN;
  localparam int WSW       = $clog2(MAX_LOG2_WIN + 1);
  localparam int DEPTH     = 1 << MAX_LOG2_WIN;
  localparam int PW        = MAX_LOG2_WIN;
  localparam int FW        = MAX_LOG2_WIN + 1;

  logic [WSW-1:0] win_c;
  logic [WSW-1:0] win_q;
  logic           flush;
  logic           full;
  logic [FW-1:0]  win_len;
  logic [FW-1:0]  fill;
  logic [FW-1:0]  fill_base;
  logic [FW-1:0]  fill_next;
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  ptr_base;
  logic [PW-1:0]  rd_ptr;

  logic signed [SUM_WIDTH-1:0]  sum      [NUM_CH];
  logic signed [SUM_WIDTH-1:0]  sum_base [NUM_CH];
  logic signed [SUM_WIDTH-1:0]  sum_next [NUM_CH];
  logic signed [DATA_WIDTH-1:0] sample   [NUM_CH];
  logic signed [DATA_WIDTH-1:0] old      [NUM_CH];
  logic signed [DATA_WIDTH-1:0] avg_c    [NUM_CH];
  logic signed [DATA_WIDTH-1:0] mem      [NUM_CH][DEPTH];

  // A flush cycle works from zeroed state so a sample accepted in the
  // same cycle becomes the first entry of the fresh window.
  always_comb begin
    win_c = (win_sel > WSW'(MAX_LOG2_WIN)) ? WSW'(MAX_LOG2_WIN) : win_sel;
    win_len   = FW'(1) << win_c;
    flush     = clr || (win_c != win_q);
    fill_base = flush ? '0 : fill;
    ptr_base  = flush ? '0 : wr_ptr;
    full      = (fill_base == win_len);
    // Depth is a power of two, so pointer wrap is free.
    rd_ptr    = ptr_base - win_len[PW-1:0];
    fill_next = full ? fill_base : fill_base + FW'(1);
    for (int c = 0; c < NUM_CH; c++) begin
      sample[c]   = data_in[c*DATA_WIDTH +: DATA_WIDTH];
      old[c]      = full ? mem[c][rd_ptr] : '0;
      sum_base[c] = flush ? '0 : sum[c];
      sum_next[c] = sum_base[c]
                  + {{(SUM_WIDTH-DATA_WIDTH){sample[c][DATA_WIDTH-1]}}, sample[c]}
                  - {{(SUM_WIDTH-DATA_WIDTH){old[c][DATA_WIDTH-1]}}, old[c]};
      // Average lies within sample range, so truncation is lossless.
      avg_c[c]    = DATA_WIDTH'(sum_next[c] >>> win_c);
    end
  end

  // Sample RAM is never cleared; the fill count masks stale entries.
  always_ff @(posedge clk) begin
    if (in_valid) begin
      for (int c = 0; c < NUM_CH; c++) begin
        mem[c][ptr_base] <= sample[c];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_q     <= '0;
      fill      <= '0;
      wr_ptr    <= '0;
      out_valid <= 1'b0;
      avg_out   <= '0;
      evict_out <= '0;
      primed    <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
        sum[c] <= '0;
      end
    end else begin
      win_q     <= win_c;
      out_valid <= in_valid;
      if (in_valid) begin
        fill   <= fill_next;
        wr_ptr <= ptr_base + PW'(1);
        primed <= (fill_next == win_len);
        for (int c = 0; c < NUM_CH; c++) begin
          sum[c] <= sum_next[c];
          avg_out[c*DATA_WIDTH +: DATA_WIDTH]   <= avg_c[c];
          evict_out[c*DATA_WIDTH +: DATA_WIDTH] <= old[c];
        end
      end else if (flush) begin
        fill   <= '0;
        wr_ptr <= '0;
        primed <= 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
          sum[c] <= '0;
        end
      end
    end
  end

endmodule
